// File: rtl/sync_fifo_pkg.sv
// Shared constants, pointer type and level helper for the synchronous byte FIFO.
package sync_fifo_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 4;
  localparam int AFULL_TH_DEF = 12;

  // One extra MSB beyond the address separates the full and empty cases.
  typedef logic [ADDR_W_DEF:0] ptr_t;

  function automatic ptr_t ptr_level(input ptr_t wr_ptr, input ptr_t rd_ptr);
    return wr_ptr - rd_ptr;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for the FIFO: one write port and one registered read port, no reset.
module sync_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // A read and a write to the same slot in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata      <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock byte FIFO with registered status flags and a one-cycle read latency.
// FIFO_STICKY_ERR_EN: overflow/underflow hold until reset instead of pulsing.
module sync_fifo_buf
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AFULL_TH = AFULL_TH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rddata,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   data_count,
  output logic              overflow,
  output logic              underflow
);

  localparam ptr_t AFULL_LVL = ptr_t'(AFULL_TH);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic afull_q, afull_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_seen_q, rd_seen_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic rd_ok, wr_ok;
  logic ovf_cond, unf_cond;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    rd_ok    = rd_en & ~empty_q;
    wr_ok    = wr_en & (~full_q | rd_ok);
    ovf_cond = wr_en & ~wr_ok;
    unf_cond = rd_en & empty_q;

    wr_ptr_d = wr_ptr_q + ptr_t'(wr_ok);
    rd_ptr_d = rd_ptr_q + ptr_t'(rd_ok);
    count_d  = ptr_level(wr_ptr_d, rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
               (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    afull_d  = (count_d >= AFULL_LVL);

    rd_valid_d = rd_ok;
    rd_seen_d  = rd_seen_q | rd_ok;
`ifdef FIFO_STICKY_ERR_EN
    ovf_d = ovf_q | ovf_cond;
    unf_d = unf_q | unf_cond;
`else
    ovf_d = ovf_cond;
    unf_d = unf_cond;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      rd_valid_q <= rd_valid_d;
      rd_seen_q  <= rd_seen_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wrdata),
    .re    (rd_ok),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // The RAM output register has no reset; mask it until a read lands after reset.
  assign rddata      = rd_seen_q ? ram_rdata : '0;
  assign rd_valid    = rd_valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign data_count  = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Self-checking bench for sync_fifo_buf: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wrdata = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rddata;
  logic       rd_valid, full, empty, almost_full, overflow, underflow;
  logic [4:0] data_count;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] q[$];
  logic [7:0] m_rddata = '0;
  bit         m_valid  = 0;
  bit         m_ovf    = 0;
  bit         m_unf    = 0;

  always #5 clk = ~clk;

  sync_fifo_buf dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wrdata      (wrdata),
    .rd_en       (rd_en),
    .rddata      (rddata),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .data_count  (data_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".rddata"},      32'(rddata),      32'(m_rddata));
    chk({where, ".rd_valid"},    32'(rd_valid),    32'(m_valid));
    chk({where, ".data_count"},  32'(data_count),  32'(q.size()));
    chk({where, ".full"},        32'(full),        32'(q.size() == 16));
    chk({where, ".empty"},       32'(empty),       32'(q.size() == 0));
    chk({where, ".almost_full"}, 32'(almost_full), 32'(q.size() >= 12));
    chk({where, ".overflow"},    32'(overflow),    32'(m_ovf));
    chk({where, ".underflow"},   32'(underflow),   32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_rddata = '0;
    m_valid  = 0;
    m_ovf    = 0;
    m_unf    = 0;
  endtask

  // One clock of traffic; the model applies the FIFO rules to its pre-edge contents.
  task automatic cyc(input string where, input bit w, input logic [7:0] d, input bit r);
    int sz;
    bit rok, wok, ocond, ucond;
    @(negedge clk);
    wr_en  = w;
    wrdata = d;
    rd_en  = r;
    @(posedge clk);
    sz    = q.size();
    rok   = r && (sz > 0);
    wok   = w && ((sz < 16) || rok);
    ocond = w && !wok;
    ucond = r && (sz == 0);
    if (rok) m_rddata = q.pop_front();
    if (wok) q.push_back(d);
    m_valid = rok;
`ifdef FIFO_STICKY_ERR_EN
    m_ovf = m_ovf | ocond;
    m_unf = m_unf | ucond;
`else
    m_ovf = ocond;
    m_unf = ucond;
`endif
    #1;
    check_all(where);
  endtask

  // Reset asserted between edges with the current inputs still applied.
  task automatic pulse_reset(input string where);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all({where, ".async"});
    @(posedge clk);
    #1 check_all({where, ".held"});
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all("por");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 5; i++) cyc("idle", 0, 8'h00, 0);

    for (int i = 1; i <= 31; i++) cyc("fill31", 1, 8'(i), 0);
    for (int i = 0; i < 15; i++) cyc("read15", 0, 8'h00, 1);
    cyc("read15.tail", 0, 8'h00, 0);
    chk("read15.last", 32'(rddata), 32'd15);

    pulse_reset("rst_a");
    for (int i = 1; i <= 16; i++) cyc("fill16", 1, 8'(i), 0);
    for (int i = 0; i < 4; i++) cyc("full_rw", 1, 8'hA0 + 8'(i), 1);
    for (int i = 0; i < 16; i++) cyc("drain", 0, 8'h00, 1);
    cyc("drain.tail", 0, 8'h00, 0);
    chk("drain.last", 32'(rddata), 32'hA3);

    cyc("unf_rd", 0, 8'h00, 1);
    cyc("empty_rw", 1, 8'h55, 1);
    cyc("read55", 0, 8'h00, 1);
    cyc("read55.tail", 0, 8'h00, 0);
    chk("read55.data", 32'(rddata), 32'h55);

    for (int i = 0; i < 11; i++) cyc("fill11", 1, 8'h30 + 8'(i), 0);
    cyc("to9.a", 0, 8'h00, 1);
    cyc("to9.b", 0, 8'h00, 1);
    chk("to9.count", 32'(data_count), 32'd9);
    @(negedge clk) rd_en = 1'b1;
    pulse_reset("rst_mid");
    cyc("post_rst", 0, 8'h00, 0);
    cyc("post_wr", 1, 8'h77, 0);
    cyc("post_rd", 0, 8'h00, 1);
    cyc("post.tail", 0, 8'h00, 0);
    chk("post.data", 32'(rddata), 32'h77);

    for (int ph = 0; ph < 5; ph++) begin
      int wp;
      int rp;
      wp = (ph % 2 == 0) ? 80 : 25;
      rp = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 100; i++) begin
        cyc("rand", ($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) < rp));
      end
    end

    pulse_reset("rst_end");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
